// File: rtl/n_set_cache_tag_lookup_controller.sv
// Tag lookup/fill controller: resolves lookups into hit, cold fill or eviction and drives the LRU policy.
// Result 2 cycles after accept (hit/cold) or 1 cycle after pol_done_i (eviction); ready_o only in IDLE.
module n_set_cache_tag_lookup_controller #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE       = 4,
    parameter int BW_TAG               = 20,
    localparam int BW_CAP   = $clog2(CACHE_BLOCK_CAPACITY),
    localparam int BW_GRP   = $clog2(CACHE_SET_SIZE),
    localparam int BW_SET   = BW_CAP - BW_GRP,
    localparam int BW_SET_P = (BW_SET > 0) ? BW_SET : 1,
    localparam int BW_GRP_P = (BW_GRP > 0) ? BW_GRP : 1,
    localparam int N_SET    = 1 << BW_SET
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic [BW_TAG-1:0]   req_tag_i,
    input  logic [BW_SET_P-1:0] req_set_i,
    input  logic                flush_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic                hit_o,
    output logic [BW_CAP-1:0]   addr_o,
    output logic                evict_o,
    output logic [BW_TAG-1:0]   evict_tag_o,
    output logic                pol_hit_o,
    output logic                pol_miss_o,
    output logic [BW_CAP-1:0]   pol_addr_o,
    input  logic                pol_done_i,
    input  logic [BW_CAP-1:0]   pol_addr_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_GUARD,
        S_MISS_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [BW_TAG-1:0]         tag_mem_q [N_SET][CACHE_SET_SIZE];
    logic [CACHE_SET_SIZE-1:0] vld_q     [N_SET];

    logic [BW_TAG-1:0]   req_tag_q;
    logic [BW_SET_P-1:0] req_set_q;
    logic [BW_SET_P-1:0] set_idx;

    logic                res_hit_q, res_hit_d;
    logic                res_evict_q, res_evict_d;
    logic [BW_CAP-1:0]   res_addr_q, res_addr_d;
    logic [BW_TAG-1:0]   res_evict_tag_q, res_evict_tag_d;

    logic                accept, flush, wr_en;
    logic [BW_GRP_P-1:0] wr_grp;
    logic                hit_any, free_any;
    logic [BW_GRP_P-1:0] hit_way, free_way, pol_grp;

    function automatic logic [BW_CAP-1:0] mk_addr(input logic [BW_GRP_P-1:0] g,
                                                  input logic [BW_SET_P-1:0] s);
        logic [BW_CAP-1:0] a;
        a = BW_CAP'(g) << BW_SET;
        if (BW_SET > 0) a = a | BW_CAP'(s);
        return a;
    endfunction

    // Fully associative builds have a single set; the latched set field is meaningless there.
    assign set_idx = (N_SET == 1) ? '0 : req_set_q;
    assign pol_grp = BW_GRP_P'(pol_addr_i >> BW_SET);

    // Descending scan so the lowest-index hit/free way wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = CACHE_SET_SIZE - 1; w >= 0; w--) begin
            if (vld_q[set_idx][w] && (tag_mem_q[set_idx][w] == req_tag_q)) begin
                hit_any = 1'b1;
                hit_way = BW_GRP_P'(w);
            end
            if (!vld_q[set_idx][w]) begin
                free_any = 1'b1;
                free_way = BW_GRP_P'(w);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        flush           = 1'b0;
        wr_en           = 1'b0;
        wr_grp          = '0;
        res_hit_d       = res_hit_q;
        res_evict_d     = res_evict_q;
        res_addr_d      = res_addr_q;
        res_evict_tag_d = res_evict_tag_q;
        ready_o         = 1'b0;
        valid_o         = 1'b0;
        hit_o           = 1'b0;
        addr_o          = '0;
        evict_o         = 1'b0;
        evict_tag_o     = '0;
        pol_hit_o       = 1'b0;
        pol_miss_o      = 1'b0;
        pol_addr_o      = '0;
        if (!reset_i) begin
            case (state_q)
                S_IDLE: begin
                    ready_o = 1'b1;
                    if (flush_i) begin
                        flush = 1'b1;
                    end else if (req_i) begin
                        accept  = 1'b1;
                        state_d = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    res_evict_d     = 1'b0;
                    res_evict_tag_d = '0;
                    if (hit_any) begin
                        pol_hit_o  = 1'b1;
                        pol_addr_o = mk_addr(hit_way, set_idx);
                        res_hit_d  = 1'b1;
                        res_addr_d = mk_addr(hit_way, set_idx);
                        state_d    = S_RESP;
                    end else if (free_any) begin
                        // Cold fill still pulses hit so the policy marks the new way MRU.
                        wr_en      = 1'b1;
                        wr_grp     = free_way;
                        pol_hit_o  = 1'b1;
                        pol_addr_o = mk_addr(free_way, set_idx);
                        res_hit_d  = 1'b0;
                        res_addr_d = mk_addr(free_way, set_idx);
                        state_d    = S_RESP;
                    end else begin
                        pol_miss_o = 1'b1;
                        pol_addr_o = mk_addr('0, set_idx);
                        state_d    = S_MISS_GUARD;
                    end
                end
                S_MISS_GUARD: begin
                    pol_addr_o = mk_addr('0, set_idx);
                    state_d    = S_MISS_WAIT;
                end
                S_MISS_WAIT: begin
                    pol_addr_o = mk_addr('0, set_idx);
                    if (pol_done_i) begin
                        wr_en           = 1'b1;
                        wr_grp          = pol_grp;
                        res_hit_d       = 1'b0;
                        res_evict_d     = 1'b1;
                        res_addr_d      = mk_addr(pol_grp, set_idx);
                        res_evict_tag_d = tag_mem_q[set_idx][pol_grp];
                        state_d         = S_RESP;
                    end
                end
                S_RESP: begin
                    valid_o     = 1'b1;
                    hit_o       = res_hit_q;
                    addr_o      = res_addr_q;
                    evict_o     = res_evict_q;
                    evict_tag_o = res_evict_tag_q;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            res_hit_q       <= 1'b0;
            res_evict_q     <= 1'b0;
            res_addr_q      <= '0;
            res_evict_tag_q <= '0;
            for (int s = 0; s < N_SET; s++) vld_q[s] <= '0;
        end else begin
            state_q         <= state_d;
            res_hit_q       <= res_hit_d;
            res_evict_q     <= res_evict_d;
            res_addr_q      <= res_addr_d;
            res_evict_tag_q <= res_evict_tag_d;
            if (flush) begin
                for (int s = 0; s < N_SET; s++) vld_q[s] <= '0;
            end else if (wr_en) begin
                vld_q[set_idx][wr_grp] <= 1'b1;
            end
        end
    end

    // Tag storage and request latches carry no reset; valid bits qualify them.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            req_tag_q <= req_tag_i;
            req_set_q <= req_set_i;
        end
        if (wr_en) tag_mem_q[set_idx][wr_grp] <= req_tag_q;
    end

endmodule

// File: tb/tb_n_set_cache_tag_lookup_controller.sv
// Bench for the tag lookup controller: 8-block/4-way and 8-block fully associative instances
// driven through a shared request port, checked against an array model of tag/valid state.
module tb_n_set_cache_tag_lookup_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, flush, done, sel;
    logic [19:0] req_tag;
    logic [0:0]  req_set;
    logic [2:0]  pol_addr_in;

    logic        a_ready, a_valid, a_hit, a_evict, a_pol_hit, a_pol_miss;
    logic [2:0]  a_addr, a_pol_addr;
    logic [19:0] a_etag;
    logic        b_ready, b_valid, b_hit, b_evict, b_pol_hit, b_pol_miss;
    logic [2:0]  b_addr, b_pol_addr;
    logic [19:0] b_etag;

    n_set_cache_tag_lookup_controller #(
        .CACHE_BLOCK_CAPACITY(8), .CACHE_SET_SIZE(4), .BW_TAG(20)
    ) u_dut_a (
        .clock_i(clk), .reset_i(rst), .req_i(req & ~sel), .req_tag_i(req_tag),
        .req_set_i(req_set), .flush_i(flush & ~sel), .ready_o(a_ready), .valid_o(a_valid),
        .hit_o(a_hit), .addr_o(a_addr), .evict_o(a_evict), .evict_tag_o(a_etag),
        .pol_hit_o(a_pol_hit), .pol_miss_o(a_pol_miss), .pol_addr_o(a_pol_addr),
        .pol_done_i(done), .pol_addr_i(pol_addr_in)
    );

    n_set_cache_tag_lookup_controller #(
        .CACHE_BLOCK_CAPACITY(8), .CACHE_SET_SIZE(8), .BW_TAG(20)
    ) u_dut_b (
        .clock_i(clk), .reset_i(rst), .req_i(req & sel), .req_tag_i(req_tag),
        .req_set_i(req_set), .flush_i(flush & sel), .ready_o(b_ready), .valid_o(b_valid),
        .hit_o(b_hit), .addr_o(b_addr), .evict_o(b_evict), .evict_tag_o(b_etag),
        .pol_hit_o(b_pol_hit), .pol_miss_o(b_pol_miss), .pol_addr_o(b_pol_addr),
        .pol_done_i(done), .pol_addr_i(pol_addr_in)
    );

    logic        o_ready, o_valid, o_hit, o_evict, o_pol_hit, o_pol_miss;
    logic [2:0]  o_addr, o_pol_addr;
    logic [19:0] o_etag;
    assign o_ready    = sel ? b_ready    : a_ready;
    assign o_valid    = sel ? b_valid    : a_valid;
    assign o_hit      = sel ? b_hit      : a_hit;
    assign o_evict    = sel ? b_evict    : a_evict;
    assign o_pol_hit  = sel ? b_pol_hit  : a_pol_hit;
    assign o_pol_miss = sel ? b_pol_miss : a_pol_miss;
    assign o_addr     = sel ? b_addr     : a_addr;
    assign o_pol_addr = sel ? b_pol_addr : a_pol_addr;
    assign o_etag     = sel ? b_etag     : a_etag;

    int checks   = 0;
    int failures = 0;

    // Reference state: what each (set, way) should hold, independent of the DUT's encoding.
    int          m_ways;
    int          m_bwset;
    logic [19:0] m_tag [2][8];
    bit          m_vld [2][8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int mk(input int g, input int s);
        return (g << m_bwset) | s;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 8; w++) m_vld[s][w] = 1'b0;
    endtask

    task automatic do_req(input logic [19:0] tag, input int set, input int delay,
                          input bit stale, input bit rst_wait, input int g_force);
        int s, w_hit, w_free, g, g_stale;
        logic exp_hit, exp_ev;
        int exp_addr;
        logic [19:0] exp_et;
        s = (m_bwset == 0) ? 0 : set;
        w_hit = -1;
        w_free = -1;
        for (int w = 0; w < m_ways; w++) begin
            if (m_vld[s][w] && m_tag[s][w] == tag && w_hit < 0) w_hit = w;
            if (!m_vld[s][w] && w_free < 0) w_free = w;
        end
        g = (g_force >= 0) ? g_force : int'($urandom_range(m_ways - 1));
        g_stale = (g + 1) % m_ways;

        @(negedge clk);
        check("ready_idle", 32'(o_ready), 32'd1);
        req = 1'b1;
        req_tag = tag;
        req_set = 1'(set);
        if (stale) begin
            done = 1'b1;
            pol_addr_in = 3'(mk(g_stale, 0) | ((m_bwset > 0) ? int'($urandom_range(1)) : 0));
        end
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        if (w_hit >= 0 || w_free >= 0) begin
            int w;
            w = (w_hit >= 0) ? w_hit : w_free;
            check("lookup_pol_hit", 32'(o_pol_hit), 32'd1);
            check("lookup_pol_miss", 32'(o_pol_miss), 32'd0);
            check("lookup_pol_addr", 32'(o_pol_addr), 32'(mk(w, s)));
            exp_hit = (w_hit >= 0);
            exp_ev = 1'b0;
            exp_et = '0;
            exp_addr = mk(w, s);
            if (w_hit < 0) begin
                m_tag[s][w] = tag;
                m_vld[s][w] = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end else begin
            check("miss_pol_hit", 32'(o_pol_hit), 32'd0);
            check("miss_pol_miss", 32'(o_pol_miss), 32'd1);
            check("miss_pol_addr", 32'(o_pol_addr), 32'(mk(0, s)));
            @(posedge clk);
            @(negedge clk);
            check("guard_pol_pulse", 32'({o_pol_hit, o_pol_miss, o_valid}), 32'd0);
            check("guard_pol_addr", 32'(o_pol_addr), 32'(mk(0, s)));
            @(posedge clk);
            if (rst_wait) begin
                @(negedge clk);
                rst = 1'b1;
                done = 1'b0;
                #1;
                check("rst_ready", 32'(o_ready), 32'd0);
                check("rst_valid", 32'(o_valid), 32'd0);
                check("rst_pol_addr", 32'(o_pol_addr), 32'd0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("post_rst_ready", 32'(o_ready), 32'd1);
                check("post_rst_valid", 32'(o_valid), 32'd0);
                model_clear();
                return;
            end
            for (int i = 0; i < (stale ? 0 : delay); i++) begin
                @(negedge clk);
                done = 1'b0;
                check("wait_pol_addr", 32'(o_pol_addr), 32'(mk(0, s)));
                check("wait_valid", 32'(o_valid), 32'd0);
                @(posedge clk);
            end
            @(negedge clk);
            check("wait_pol_addr", 32'(o_pol_addr), 32'(mk(0, s)));
            check("wait_valid", 32'(o_valid), 32'd0);
            done = 1'b1;
            pol_addr_in = 3'(mk(g, 0) | ((m_bwset > 0) ? int'($urandom_range(1)) : 0));
            @(posedge clk);
            @(negedge clk);
            exp_hit = 1'b0;
            exp_ev = 1'b1;
            exp_et = m_tag[s][g];
            exp_addr = mk(g, s);
            m_tag[s][g] = tag;
        end
        done = 1'b0;
        check("resp_valid", 32'(o_valid), 32'd1);
        check("resp_hit", 32'(o_hit), 32'(exp_hit));
        check("resp_addr", 32'(o_addr), 32'(exp_addr));
        check("resp_evict", 32'(o_evict), 32'(exp_ev));
        check("resp_evict_tag", 32'(o_etag), 32'(exp_et));
        check("resp_pol_quiet", 32'({o_pol_hit, o_pol_miss, o_pol_addr}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle_after_resp", 32'({o_ready, o_valid, o_hit, o_evict}), 32'b1000);
        check("idle_results_zero", 32'({o_addr, o_etag}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        flush = 1'b0;
        done = 1'b0;
        sel = 1'b0;
        req_tag = '0;
        req_set = '0;
        pol_addr_in = '0;
        m_ways = 4;
        m_bwset = 1;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(o_ready), 32'd0);
        check("reset_strobes", 32'({o_valid, o_hit, o_evict, o_pol_hit, o_pol_miss}), 32'd0);
        check("reset_buses", 32'({o_addr, o_pol_addr, o_etag}), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_release_ready", 32'(o_ready), 32'd1);

        // Cold fill, hit, set-0 fill, eviction with done 3 cycles after the miss pulse
        do_req(20'h11, 1, 0, 0, 0, -1);
        do_req(20'h11, 1, 0, 0, 0, -1);
        for (int i = 0; i < 4; i++) do_req(20'h20 + 20'(i), 0, 0, 0, 0, -1);
        check("fill_way2_tag", 32'(m_tag[0][2]), 32'h22);
        do_req(20'h24, 0, 1, 0, 0, 2);
        do_req(20'h24, 0, 0, 0, 0, -1);
        do_req(20'h22, 0, 2, 0, 0, 1);
        // Stale done held high across lookup and guard
        do_req(20'h30, 0, 0, 1, 0, 3);

        // Flush with a simultaneous request
        @(negedge clk);
        flush = 1'b1;
        req = 1'b1;
        req_tag = 20'h55;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        req = 1'b0;
        check("flush_req_rejected", 32'({o_ready, o_pol_hit, o_pol_miss}), 32'b100);
        model_clear();
        do_req(20'h11, 1, 0, 0, 0, -1);
        do_req(20'h24, 0, 0, 0, 0, -1);

        // Reset while waiting on the policy
        for (int i = 0; i < 3; i++) do_req(20'h40 + 20'(i), 1, 0, 0, 0, -1);
        do_req(20'h43, 1, 0, 0, 1, -1);
        do_req(20'h11, 1, 0, 0, 0, -1);

        // Randomized traffic over a small tag pool
        for (int n = 0; n < 150; n++)
            do_req(20'h100 + 20'($urandom_range(11)), int'($urandom_range(1)),
                   int'($urandom_range(3)), ($urandom_range(3) == 0), 0, -1);

        // Fully associative instance
        @(negedge clk);
        sel = 1'b1;
        m_ways = 8;
        m_bwset = 0;
        model_clear();
        for (int i = 0; i < 8; i++) do_req(20'h200 + 20'(i), int'($urandom_range(1)), 0, 0, 0, -1);
        do_req(20'h208, int'($urandom_range(1)), 1, 0, 0, 5);
        do_req(20'h208, int'($urandom_range(1)), 0, 0, 0, -1);
        for (int n = 0; n < 40; n++)
            do_req(20'h200 + 20'($urandom_range(11)), int'($urandom_range(1)),
                   int'($urandom_range(3)), ($urandom_range(3) == 0), 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n_set_cache_tag_lookup_controller.md
# n_set_cache_tag_lookup_controller

Tag-lookup and fill controller that drives the n-set LRU replacement policy controller from the cache side. It resolves a core lookup into hit, cold fill or eviction, and issues `hit`/`miss` to the policy. On a full-set miss it waits for the policy's replacement address, then installs the new tag and reports the block address and victim tag. It sits between the cache datapath/core request port and `n_set_cache_lru_policy_controller`.

## Interface
- CACHE_BLOCK_CAPACITY, 128, total cache blocks; power of two.
- CACHE_SET_SIZE, 4, ways per set; power of two; equal to CACHE_BLOCK_CAPACITY means fully associative.
- BW_TAG, 20, tag width.
- Derived: BW_CAP=clog2(CAPACITY), BW_GRP=clog2(SET_SIZE), BW_SET=BW_CAP-BW_GRP, N_SET=2^BW_SET. Block address format is {group, set}; set is the low bits.

Ports:
- clock_i  in  1  sole clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  1  lookup request; accepted when req_i & ready_o & ~flush_i.
- req_tag_i  in  BW_TAG  lookup tag.
- req_set_i  in  max(BW_SET,1)  set index; ignored when N_SET==1.
- flush_i  in  1  invalidate all lines; honoured only in IDLE.
- ready_o  out  1  high only in IDLE.
- valid_o  out  1  one-cycle result strobe.
- hit_o  out  1  result: tag was resident.
- addr_o  out  BW_CAP  block address {group,set} of hit/installed line.
- evict_o  out  1  a valid line was replaced.
- evict_tag_o  out  BW_TAG  tag of replaced line; 0 when evict_o=0.
- pol_hit_o  out  1  one-cycle hit pulse to policy.
- pol_miss_o  out  1  one-cycle miss pulse to policy.
- pol_addr_o  out  BW_CAP  address to policy.
- pol_done_i  in  1  policy replacement address valid.
- pol_addr_i  in  BW_CAP  policy replacement address; only group bits used.

## Operation
- Storage: N_SET x SET_SIZE tag registers plus valid bits. The tag registers are not reset. The valid bits are cleared by reset_i or flush.
- FSM states: IDLE, LOOKUP, MISS_GUARD, MISS_WAIT, RESP.
- IDLE:
  - If flush_i is high, clear all valid bits this cycle and stay in IDLE; a req_i in the same cycle is not accepted.
  - Else, on an accepted req_i, latch tag and set, then go to LOOKUP.
- LOOKUP: parallel compare of all ways of the latched set.
  - Hit on way w: pol_hit_o=1 with pol_addr_o={w,set}. Go to RESP with hit=1, addr={w,set}.
  - Miss with at least one invalid way: take the lowest-index invalid way v. Write the tag and set valid. pol_hit_o=1 with {v,set}, which marks v most-recently used. Go to RESP with hit=0, evict=0.
  - Miss with all ways valid: pol_miss_o=1 with pol_addr_o={0,set}. Go to MISS_GUARD.
- MISS_GUARD: one cycle. pol_done_i is ignored here, which rejects stale done. Go to MISS_WAIT.
- MISS_WAIT: hold until pol_done_i=1. In that cycle:
  - capture g=pol_addr_i[BW_CAP-1:BW_SET];
  - copy the old tag of {g,set} to evict_tag;
  - write the new tag with valid=1;
  - go to RESP with hit=0, evict=1, addr={g,set}.
  - No timeout.
- RESP: valid_o=1 with registered hit_o/addr_o/evict_o/evict_tag_o. Go to IDLE.
- Policy interface rules:
  - pol_addr_o is held stable from LOOKUP through the end of MISS_WAIT and is 0 otherwise.
  - pol_hit_o and pol_miss_o are never high together and each lasts exactly one cycle per request.
- Fully associative (N_SET==1): the set field has zero width, addr_o equals the group, and req_set_i is ignored.

## Timing
- Reset (cycle with reset_i=1):
  - state goes to IDLE and all valid bits clear;
  - ready_o=0 during reset and 1 the first cycle after;
  - valid_o, hit_o, evict_o, pol_hit_o, pol_miss_o=0; addr_o, evict_tag_o, pol_addr_o=0.
  - Reset mid-operation aborts without a valid_o pulse.
  - The policy controller must be reset in the same cycle.
- Result outputs hold their values only during the valid_o cycle and are 0 otherwise.
- Latency (req accepted at cycle 0):
  - hit or cold fill: valid_o at cycle 2.
  - full miss: pol_miss_o at cycle 1, earliest done sample at cycle 3, valid_o the cycle after done is sampled.
- Throughput: one request per 3 cycles minimum; ready_o returns the cycle after RESP.

## Test plan
Configuration: CAPACITY=8, SET_SIZE=4 (BW_SET=1, BW_GRP=2).
- Cold fill: after reset, req tag 0x11 set 1 -> cycle 1 pol_hit_o=1, pol_addr_o=3'b001. Cycle 2 valid_o=1, hit_o=0, evict_o=0, addr_o=3'b001.
- Hit: repeat tag 0x11 set 1 -> valid_o at cycle 2 with hit_o=1, addr_o=3'b001. Exactly one pol_hit_o, no pol_miss_o.
- Eviction:
  - Setup: fill set 0 with 0x20..0x23, landing at addresses 000, 010, 100, 110.
  - Stimulus: req 0x24 set 0; the policy model asserts done 3 cycles after the miss pulse with pol_addr_i=3'b100.
  - Required: pol_miss_o once with pol_addr_o=3'b000, then valid_o with evict_o=1, evict_tag_o=0x22, addr_o=3'b100.
  - Follow-up: 0x24 then hits at 100; 0x22 misses.
- Stale done: pol_done_i held at 1 throughout, with pol_addr_i=3'b000 until the guard cycle and 3'b110 afterwards -> the install lands at 3'b110. Done is not accepted in the LOOKUP or MISS_GUARD cycles.
- Flush:
  - flush_i in IDLE with req_i high simultaneously -> req is not accepted.
  - Subsequent lookups of 0x11 and 0x24 miss with evict_o=0 (cold fills).
- Reset in MISS_WAIT -> no valid_o pulse, ready_o is 0 during reset and 1 the next cycle, and the next lookup is a cold fill.
- Fully associative: CAPACITY=SET_SIZE=8 -> eight distinct tags fill addresses 0..7, and the ninth tag evicts at the policy-supplied address.
